audio_event_scheduler: RTL

- Collects one-shot sound requests from game logic: key X/Y/Enter, hole collision, border collision, ball-to-ball collision.
- Queues them in a pending register and grants them one at a time by fixed priority.
- Each granted request drives the tone generator prescaler with a note for a fixed number of video frames, followed by a silent gap.
- Sits between game control/collision logic and the audio prescaler/tone generator.

---
 rtl/audio_event_scheduler_if.sv | 21 ++
 rtl/audio_event_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/audio_event_scheduler_if.sv
// Sound-request / tone-output bundle between game logic and the audio event scheduler.
`timescale 1ns/1ps
interface audio_event_scheduler_if;
    logic       startOfFrame;
    logic [5:0] req;
    logic       mute;
    logic [9:0] preScaleValue;
    logic       busy;
    logic [2:0] activeId;
    logic [7:0] dropCount;

    modport master (
        output startOfFrame, req, mute,
        input  preScaleValue, busy, activeId, dropCount
    );

    modport slave (
        input  startOfFrame, req, mute,
        output preScaleValue, busy, activeId, dropCount
    );
endinterface

// File: rtl/audio_event_scheduler.sv
// Queues one-shot sound requests and plays them one at a time by fixed priority, note then gap.
// Latency: 2 clk from req rise to tone while idle; requests wait in pending, no backpressure.
// Optional AUDIO_PREEMPT_EN: a higher-priority pending request interrupts the current note or gap.
`timescale 1ns/1ps
module audio_event_scheduler #(
    parameter int unsigned NOTE_FRAMES = 10,
    parameter int unsigned GAP_FRAMES  = 2
) (
    input  logic                     clk,
    input  logic                     resetN,
    audio_event_scheduler_if.slave   sched
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [7:0] NOTE_LD = 8'(NOTE_FRAMES);
    localparam logic [7:0] GAP_LD  = 8'(GAP_FRAMES);

    state_t     state_q, state_d;
    logic [5:0] pending_q, pending_d;
    logic [5:0] req_prev_q;
    logic [7:0] counter_q, counter_d;
    logic [9:0] pre_q, pre_d;
    logic [2:0] active_q, active_d;
    logic [7:0] drop_q, drop_d;

    logic [5:0] req_edge, grant_mask, drops;
    logic       win_vld, preempt, preempt_drop;
    logic [2:0] win_id;
    logic [3:0] drop_inc;
    logic [8:0] drop_sum;

    function automatic logic [9:0] tone(input logic [2:0] id);
        case (id)
            3'd0:    tone = 10'h175;
            3'd1:    tone = 10'h14C;
            3'd2:    tone = 10'h128;
            3'd3:    tone = 10'h0DD;
            3'd4:    tone = 10'h18B;
            3'd5:    tone = 10'h117;
            default: tone = 10'h000;
        endcase
    endfunction

    assign req_edge = sched.req & ~req_prev_q;

    // Lowest priority assigned first so higher ones overwrite: 3 > 5 > 4 > 0 > 1 > 2.
    always_comb begin
        win_id = 3'd7;
        if (pending_q[2]) win_id = 3'd2;
        if (pending_q[1]) win_id = 3'd1;
        if (pending_q[0]) win_id = 3'd0;
        if (pending_q[4]) win_id = 3'd4;
        if (pending_q[5]) win_id = 3'd5;
        if (pending_q[3]) win_id = 3'd3;
    end
    assign win_vld = |pending_q;

`ifdef AUDIO_PREEMPT_EN
    // Rank 0 is "nothing playing", so a gap loses to any pending request.
    function automatic logic [2:0] rank(input logic [2:0] id);
        case (id)
            3'd3:    rank = 3'd6;
            3'd5:    rank = 3'd5;
            3'd4:    rank = 3'd4;
            3'd0:    rank = 3'd3;
            3'd1:    rank = 3'd2;
            3'd2:    rank = 3'd1;
            default: rank = 3'd0;
        endcase
    endfunction
    assign preempt = (state_q != IDLE) && win_vld && (rank(win_id) > rank(active_q));
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        pre_d        = pre_q;
        active_d     = active_q;
        grant_mask   = '0;
        preempt_drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_mask = 6'b1 << win_id;
                    state_d    = PLAY;
                    counter_d  = NOTE_LD;
                    active_d   = win_id;
                    pre_d      = tone(win_id);
                end
            end
            default: begin
                if (preempt) begin
                    grant_mask   = 6'b1 << win_id;
                    preempt_drop = (state_q == PLAY);
                    state_d      = PLAY;
                    counter_d    = NOTE_LD;
                    active_d     = win_id;
                    pre_d        = tone(win_id);
                end else if (sched.startOfFrame) begin
                    if (counter_q == 8'd1) begin
                        if (state_q == PLAY) begin
                            pre_d    = '0;
                            active_d = 3'd7;
                            if (GAP_FRAMES > 0) begin
                                state_d   = GAP;
                                counter_d = GAP_LD;
                            end else begin
                                state_d   = IDLE;
                                counter_d = '0;
                            end
                        end else begin
                            state_d   = IDLE;
                            counter_d = '0;
                        end
                    end else begin
                        counter_d = counter_q - 8'd1;
                    end
                end
            end
        endcase
    end

    // An edge on a bit being granted this cycle re-arms it without counting as a drop.
    always_comb begin
        pending_d = (pending_q & ~grant_mask) | req_edge;
        drops     = req_edge & pending_q & ~grant_mask;
        drop_inc  = {3'b000, preempt_drop};
        for (int i = 0; i < 6; i++) drop_inc = drop_inc + {3'b000, drops[i]};
        drop_sum  = {1'b0, drop_q} + {5'b00000, drop_inc};
        drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            req_prev_q <= '0;
            counter_q  <= '0;
            pre_q      <= '0;
            active_q   <= 3'd7;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            req_prev_q <= sched.req;
            counter_q  <= counter_d;
            pre_q      <= pre_d;
            active_q   <= active_d;
            drop_q     <= drop_d;
        end
    end

    assign sched.preScaleValue = sched.mute ? 10'h000 : pre_q;
    assign sched.busy          = (state_q != IDLE);
    assign sched.activeId      = active_q;
    assign sched.dropCount     = drop_q;
endmodule
